// File: rtl/seg_led_pkg.sv
// Shared constants for the seg_led hex-to-7-segment decoder: segment bit
// indices, the all-off/all-on masks and the active-high glyph table.
package seg_led_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF_HI = 7'h00;
    localparam logic [6:0] SEG_ALL_HI = 7'(1 << SEG_A) | 7'(1 << SEG_B) | 7'(1 << SEG_C)
                                      | 7'(1 << SEG_D) | 7'(1 << SEG_E) | 7'(1 << SEG_F)
                                      | 7'(1 << SEG_G);

    // Active-high gfedcba patterns; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_led_rom.sv
// Combinational nibble-to-glyph lookup, active-high (segment lit = 1).
module seg_led_rom
    import seg_led_pkg::*;
(
    input  logic [3:0] x,
    output logic [6:0] pattern
);

    assign pattern = SEG_TABLE[x];

endmodule

// File: rtl/seg_led.sv
// Registered hex-to-7-segment decoder for one common-anode display digit.
// Optional lamp-test input is compiled in when SEG_LED_LAMP_TEST_EN is defined.
module seg_led
    import seg_led_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk_in,
    input  logic       btn_reset,
    input  logic [3:0] x,
    input  logic       blank,
`ifdef SEG_LED_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    output logic [6:0] z
);

    localparam logic [6:0] Z_OFF = ACTIVE_LOW ? ~SEG_OFF_HI : SEG_OFF_HI;

    logic [6:0] pattern;
    logic [6:0] next_hi;
    logic [6:0] next_z;

    seg_led_rom u_rom (
        .x       (x),
        .pattern (pattern)
    );

    // NOTE: default assignment first so every path drives next_hi and no latch is inferred.
    always_comb begin
        next_hi = pattern;
        if (blank)
            next_hi = SEG_OFF_HI;
`ifdef SEG_LED_LAMP_TEST_EN
        if (lamp_test)
            next_hi = SEG_ALL_HI;
`endif
        next_z = ACTIVE_LOW ? ~next_hi : next_hi;
    end

    // NOTE: non-blocking assignment for registered state avoids simulation races between flops.
    always_ff @(posedge clk_in or negedge btn_reset) begin
        if (!btn_reset)
            z <= Z_OFF;
        else
            z <= next_z;
    end

endmodule

// File: tb/tb_seg_led.sv
// Directed self-checking bench for seg_led: one active-low and one active-high
// instance share stimulus; lamp-test steps run when SEG_LED_LAMP_TEST_EN is defined.
module tb_seg_led;

    logic       clk_in    = 1'b0;
    logic       btn_reset = 1'b0;
    logic [3:0] x         = 4'h0;
    logic       blank     = 1'b0;
    logic       lamp_test = 1'b0;
    logic [6:0] z_lo;
    logic [6:0] z_hi;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed expected outputs for x = 0..F.
    logic [6:0] exp_lo [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] exp_hi [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_led #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk_in    (clk_in),
        .btn_reset (btn_reset),
        .x         (x),
        .blank     (blank),
`ifdef SEG_LED_LAMP_TEST_EN
        .lamp_test (lamp_test),
`endif
        .z         (z_lo)
    );

    seg_led #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk_in    (clk_in),
        .btn_reset (btn_reset),
        .x         (x),
        .blank     (blank),
`ifdef SEG_LED_LAMP_TEST_EN
        .lamp_test (lamp_test),
`endif
        .z         (z_hi)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        // Reset held while the clock runs.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_lo", z_lo, 7'h7F);
            check("reset_hi", z_hi, 7'h00);
        end

        // Release between edges: still off until the next posedge.
        @(negedge clk_in);
        btn_reset = 1'b1;
        #1;
        check("release_lo", z_lo, 7'h7F);
        check("release_hi", z_hi, 7'h00);

        // Sweep 0..F, one nibble per cycle, with one-cycle lag.
        for (int i = 0; i < 16; i++) begin
            if (i != 0) begin
                @(negedge clk_in);
                x = 4'(i);
                #1;
                check("lag_lo", z_lo, exp_lo[i-1]);
            end
            tick();
            check("sweep_lo", z_lo, exp_lo[i]);
            check("sweep_hi", z_hi, exp_hi[i]);
        end

        // Wrap F -> 0.
        @(negedge clk_in);
        x = 4'h0;
        tick();
        check("wrap_lo", z_lo, 7'h40);

        // Blank over x=8, then release.
        @(negedge clk_in);
        x = 4'h8;
        blank = 1'b1;
        tick();
        check("blank_lo", z_lo, 7'h7F);
        check("blank_hi", z_hi, 7'h00);
        @(negedge clk_in);
        blank = 1'b0;
        tick();
        check("unblank_lo", z_lo, 7'h00);
        check("unblank_hi", z_hi, 7'h7F);

        // Active-high instance on x=3.
        @(negedge clk_in);
        x = 4'h3;
        tick();
        check("x3_hi", z_hi, 7'h4F);
        check("x3_lo", z_lo, 7'h30);

`ifdef SEG_LED_LAMP_TEST_EN
        // Lamp test overrides blank.
        @(negedge clk_in);
        blank = 1'b1;
        lamp_test = 1'b1;
        tick();
        check("lamp_lo", z_lo, 7'h00);
        check("lamp_hi", z_hi, 7'h7F);
        @(negedge clk_in);
        lamp_test = 1'b0;
        tick();
        check("lamp_rel_lo", z_lo, 7'h7F);
        check("lamp_rel_hi", z_hi, 7'h00);
        @(negedge clk_in);
        blank = 1'b0;
`endif

        // Asynchronous reset mid-cycle while x=1.
        @(negedge clk_in);
        x = 4'h1;
        tick();
        check("x1_lo", z_lo, 7'h79);
        check("x1_hi", z_hi, 7'h06);
        #2;
        btn_reset = 1'b0;
        #1;
        check("async_rst_lo", z_lo, 7'h7F);
        check("async_rst_hi", z_hi, 7'h00);
        tick();
        check("held_rst_lo", z_lo, 7'h7F);

        // Recover from reset.
        @(negedge clk_in);
        btn_reset = 1'b1;
        #1;
        check("rerelease_lo", z_lo, 7'h7F);
        tick();
        check("recover_lo", z_lo, 7'h79);
        check("recover_hi", z_hi, 7'h06);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
